// File: rtl/status_interrupt_controller.sv
// Status register (NZCV, mode, interrupt enable) with an edge-triggered,
// fixed-priority interrupt controller and a nested saved-status stack.
module status_interrupt_controller #(
  parameter int IRQ_COUNT   = 4,
  parameter int STACK_DEPTH = 4,
  localparam int IDX_W      = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           update_mode,
  input  logic                 alu_negative,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  input  logic                 bs_negative,
  input  logic                 bs_zero,
  input  logic                 bs_carry,
  input  logic [IRQ_COUNT-1:0] irq_lines,
  input  logic                 irq_mask_write,
  input  logic [IRQ_COUNT-1:0] irq_mask_data,
  input  logic                 instruction_boundary,
  input  logic                 irq_ack,
  output logic                 negative_flag,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 overflow_flag,
  output logic                 mode_flag,
  output logic                 interrupt_enable_flag,
  output logic                 take_interrupt,
  output logic [IDX_W-1:0]     irq_index,
  output logic [IRQ_COUNT-1:0] pending,
  output logic [DEPTH_W-1:0]   nest_depth,
  output logic                 stack_underflow
);

  // state    | meaning
  // READY    | may take an interrupt at an instruction boundary
  // WAIT_ACK | take_interrupt raised, waiting for irq_ack from the sequencer
  localparam logic [0:0] ST_READY    = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] CMD_NZCV_ALU = 4'd1;
  localparam logic [3:0] CMD_NZ_ALU   = 4'd2;
  localparam logic [3:0] CMD_NZC_BS   = 4'd3;
  localparam logic [3:0] CMD_MODE_CLR = 4'd4;
  localparam logic [3:0] CMD_MODE_SET = 4'd5;
  localparam logic [3:0] CMD_RETURN   = 4'd6;
  localparam logic [3:0] CMD_IE_SET   = 4'd7;
  localparam logic [3:0] CMD_IE_CLR   = 4'd8;

  logic [0:0]           state;
  logic [IRQ_COUNT-1:0] irq_mask;
  logic [IRQ_COUNT-1:0] irq_prev;
  logic [IRQ_COUNT-1:0] eligible;
  logic [IRQ_COUNT-1:0] clear_vec;
  logic [IRQ_COUNT-1:0] pending_nxt;
  logic [IDX_W-1:0]     winner;
  logic                 n_nxt, z_nxt, c_nxt, v_nxt, mode_nxt, ie_nxt;
  logic                 take_go;
  logic                 pop_go;
  logic                 underflow_go;
  logic [DEPTH_W-1:0]   depth_m1;
  logic [SP_W-1:0]      push_ptr;
  logic [SP_W-1:0]      pop_ptr;
  logic [5:0]           push_word;
  logic [5:0]           pop_word;
  logic [5:0]           stack_mem [STACK_DEPTH];

  assign eligible = pending & irq_mask;

  always_comb begin
    winner = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (eligible[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    n_nxt    = negative_flag;
    z_nxt    = zero_flag;
    c_nxt    = carry_flag;
    v_nxt    = overflow_flag;
    mode_nxt = mode_flag;
    ie_nxt   = interrupt_enable_flag;
    case (update_mode)
      CMD_NZCV_ALU: {n_nxt, z_nxt, c_nxt, v_nxt} = {alu_negative, alu_zero, alu_carry, alu_overflow};
      CMD_NZ_ALU:   {n_nxt, z_nxt} = {alu_negative, alu_zero};
      CMD_NZC_BS:   {n_nxt, z_nxt, c_nxt} = {bs_negative, bs_zero, bs_carry};
      CMD_MODE_CLR: mode_nxt = 1'b0;
      CMD_MODE_SET: mode_nxt = 1'b1;
      CMD_IE_SET:   ie_nxt = 1'b1;
      CMD_IE_CLR:   ie_nxt = 1'b0;
      default:      ;
    endcase
  end

  // Return and take are mutually exclusive: a return cycle never takes.
  assign take_go = (state == ST_READY) && interrupt_enable_flag && instruction_boundary &&
                   (eligible != '0) && (nest_depth < DEPTH_W'(STACK_DEPTH)) &&
                   (update_mode != CMD_RETURN);
  assign pop_go       = (update_mode == CMD_RETURN) && (nest_depth != '0);
  assign underflow_go = (update_mode == CMD_RETURN) && (nest_depth == '0);

  assign depth_m1  = nest_depth - DEPTH_W'(1);
  assign push_ptr  = nest_depth[SP_W-1:0];
  assign pop_ptr   = depth_m1[SP_W-1:0];
  assign push_word = {n_nxt, z_nxt, c_nxt, v_nxt, mode_nxt, ie_nxt};
  assign pop_word  = stack_mem[pop_ptr];

  // A fresh edge on a line wins over the same-cycle clear of that line.
  assign clear_vec   = take_go ? (IRQ_COUNT'(1) << winner) : '0;
  assign pending_nxt = (pending & ~clear_vec) | (irq_lines & ~irq_prev);

  always_ff @(posedge clock) begin
    if (take_go) stack_mem[push_ptr] <= push_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      negative_flag         <= 1'b0;
      zero_flag             <= 1'b0;
      carry_flag            <= 1'b0;
      overflow_flag         <= 1'b0;
      mode_flag             <= 1'b0;
      interrupt_enable_flag <= 1'b0;
    end else if (pop_go) begin
      {negative_flag, zero_flag, carry_flag, overflow_flag,
       mode_flag, interrupt_enable_flag} <= pop_word;
    end else begin
      negative_flag         <= n_nxt;
      zero_flag             <= z_nxt;
      carry_flag            <= c_nxt;
      overflow_flag         <= v_nxt;
      mode_flag             <= take_go ? 1'b1 : mode_nxt;
      interrupt_enable_flag <= take_go ? 1'b0 : ie_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_mask        <= '0;
      irq_prev        <= '0;
      pending         <= '0;
      nest_depth      <= '0;
      stack_underflow <= 1'b0;
    end else begin
      irq_prev <= irq_lines;
      pending  <= pending_nxt;
      if (irq_mask_write) irq_mask <= irq_mask_data;
      if (take_go)        nest_depth <= nest_depth + DEPTH_W'(1);
      else if (pop_go)    nest_depth <= depth_m1;
      if (underflow_go)   stack_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_READY;
      take_interrupt <= 1'b0;
      irq_index      <= '0;
    end else begin
      case (state)
        ST_READY: begin
          if (take_go) begin
            state          <= ST_WAIT_ACK;
            take_interrupt <= 1'b1;
            irq_index      <= winner;
          end
        end
        ST_WAIT_ACK: begin
          if (irq_ack) begin
            state          <= ST_READY;
            take_interrupt <= 1'b0;
          end
        end
        default: begin
          state          <= ST_READY;
          take_interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_interrupt_controller.sv
// Scenario bench for status_interrupt_controller: stimulus tables per task,
// expected snapshots queued when driven and compared after each clock edge.
module tb_status_interrupt_controller;

  logic       clock;
  logic       reset;
  logic [3:0] update_mode;
  logic       alu_negative, alu_zero, alu_carry, alu_overflow;
  logic       bs_negative, bs_zero, bs_carry;
  logic [3:0] irq_lines;
  logic       irq_mask_write;
  logic [3:0] irq_mask_data;
  logic       instruction_boundary;
  logic       irq_ack;
  logic       negative_flag, zero_flag, carry_flag, overflow_flag;
  logic       mode_flag, interrupt_enable_flag;
  logic       take_interrupt;
  logic [1:0] irq_index;
  logic [3:0] pending;
  logic [1:0] nest_depth;
  logic       stack_underflow;

  int vectors;
  int miscompares;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [3:0]  alu;
    logic [2:0]  bs;
    logic [3:0]  lines;
    logic        mw;
    logic [3:0]  md;
    logic        bnd;
    logic        ack;
    logic [15:0] exp;
  } step_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];

  status_interrupt_controller #(.IRQ_COUNT(4), .STACK_DEPTH(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .update_mode           (update_mode),
    .alu_negative          (alu_negative),
    .alu_zero              (alu_zero),
    .alu_carry             (alu_carry),
    .alu_overflow          (alu_overflow),
    .bs_negative           (bs_negative),
    .bs_zero               (bs_zero),
    .bs_carry              (bs_carry),
    .irq_lines             (irq_lines),
    .irq_mask_write        (irq_mask_write),
    .irq_mask_data         (irq_mask_data),
    .instruction_boundary  (instruction_boundary),
    .irq_ack               (irq_ack),
    .negative_flag         (negative_flag),
    .zero_flag             (zero_flag),
    .carry_flag            (carry_flag),
    .overflow_flag         (overflow_flag),
    .mode_flag             (mode_flag),
    .interrupt_enable_flag (interrupt_enable_flag),
    .take_interrupt        (take_interrupt),
    .irq_index             (irq_index),
    .pending               (pending),
    .nest_depth            (nest_depth),
    .stack_underflow       (stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Snapshot layout: {take, index[1:0], pending[3:0], depth[1:0], underflow, N,Z,C,V,mode,I}
  function automatic logic [15:0] ew(logic t, logic [1:0] idx, logic [3:0] pend,
                                     logic [1:0] dep, logic unf, logic [5:0] f);
    return {t, idx, pend, dep, unf, f};
  endfunction

  function automatic logic [15:0] obs();
    return {take_interrupt, irq_index, pending, nest_depth, stack_underflow,
            negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag,
            interrupt_enable_flag};
  endfunction

  function automatic step_t mk(string name, logic [3:0] cmd, logic [3:0] alu, logic [2:0] bs,
                               logic [3:0] lines, logic mw, logic [3:0] md, logic bnd,
                               logic ack, logic [15:0] exp);
    step_t s;
    s.name = name; s.cmd = cmd; s.alu = alu; s.bs = bs; s.lines = lines;
    s.mw = mw; s.md = md; s.bnd = bnd; s.ack = ack; s.exp = exp;
    return s;
  endfunction

  task automatic drive(step_t s);
    update_mode = s.cmd;
    {alu_negative, alu_zero, alu_carry, alu_overflow} = s.alu;
    {bs_negative, bs_zero, bs_carry} = s.bs;
    irq_lines            = s.lines;
    irq_mask_write       = s.mw;
    irq_mask_data        = s.md;
    instruction_boundary = s.bnd;
    irq_ack              = s.ack;
  endtask

  task automatic do_reset(logic [3:0] lines);
    reset = 1'b0;
    drive(mk("rst", 4'd0, 4'd0, 3'd0, lines, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0));
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b0;
    drive(mk("rst", 4'd7, 4'hF, 3'h7, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 16'd0));
    @(posedge clock);
    #1;
    sb.push_back('{"reset_hold", 16'd0});
    e = sb.pop_front();
    vectors++;
    if (obs() !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_basic_take();
    step_t s[$];
    sb_t e;
    do_reset(4'b0000);
    s.push_back(mk("t1_ie",   4'd7, 4'd0, 3'd0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t1_edge", 4'd0, 4'd0, 3'd0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b0100, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t1_take", 4'd0, 4'd0, 3'd0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd2, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t1_ack",  4'd0, 4'd0, 3'd0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd2, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t1_ret",  4'd6, 4'd0, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd2, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_flags();
    step_t s[$];
    sb_t e;
    do_reset(4'b0000);
    s.push_back(mk("t2_ie",    4'd7, 4'b0000, 3'b000, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t2_nzcv",  4'd1, 4'b1010, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0001, 2'd0, 1'b0, 6'b101001)));
    s.push_back(mk("t2_take",  4'd0, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd0, 4'b0000, 2'd1, 1'b0, 6'b101010)));
    s.push_back(mk("t2_nz",    4'd2, 4'b0101, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 6'b011010)));
    s.push_back(mk("t2_ret",   4'd6, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b101001)));
    s.push_back(mk("t2_bs",    4'd3, 4'b1111, 3'b010, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b010001)));
    s.push_back(mk("t2_mset",  4'd5, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b010011)));
    s.push_back(mk("t2_mclr",  4'd4, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b010001)));
    s.push_back(mk("t2_iclr",  4'd8, 4'b0000, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b010000)));
    s.push_back(mk("t2_v",     4'd1, 4'b0001, 3'b000, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000100)));
    s.push_back(mk("t2_hold9", 4'd9, 4'b1111, 3'b111, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000100)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_priority_mask();
    step_t s[$];
    sb_t e;
    do_reset(4'b0000);
    s.push_back(mk("t3_ie",     4'd7, 4'd0, 3'd0, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t3_edges",  4'd0, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b1010, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t3_take3",  4'd0, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd3, 4'b0010, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t3_ackmsk", 4'd7, 4'd0, 3'd0, 4'b1010, 1'b1, 4'b1111, 1'b1, 1'b1, ew(1'b0, 2'd3, 4'b0010, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t3_take1",  4'd0, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd1, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t3_ack",    4'd0, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd1, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t3_ret2",   4'd6, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t3_ret1",   4'd6, 4'd0, 3'd0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd1, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_stack_full();
    step_t s[$];
    sb_t e;
    do_reset(4'b0000);
    s.push_back(mk("t4_ie",    4'd7, 4'd0, 3'd0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t4_e1",    4'd0, 4'd0, 3'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b0010, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t4_tk1",   4'd0, 4'd0, 3'd0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t4_ack1",  4'd7, 4'd0, 3'd0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t4_e2",    4'd0, 4'd0, 3'd0, 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd1, 4'b0100, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t4_tk2",   4'd0, 4'd0, 3'd0, 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd2, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t4_ack2",  4'd7, 4'd0, 3'd0, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd2, 4'b0000, 2'd2, 1'b0, 6'b000011)));
    s.push_back(mk("t4_e0",    4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd2, 4'b0001, 2'd2, 1'b0, 6'b000011)));
    s.push_back(mk("t4_full",  4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd2, 4'b0001, 2'd2, 1'b0, 6'b000011)));
    s.push_back(mk("t4_ret",   4'd6, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd2, 4'b0001, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t4_tk0",   4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd0, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t4_ack0",  4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd0, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_underflow_reset();
    step_t s[$];
    sb_t e;
    do_reset(4'b0000);
    s.push_back(mk("t5_nz",   4'd1, 4'b1100, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b0, 6'b110000)));
    s.push_back(mk("t5_unf",  4'd6, 4'b0000, 3'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b1, 6'b110000)));
    s.push_back(mk("t5_ie",   4'd7, 4'b0000, 3'd0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0000, 2'd0, 1'b1, 6'b110001)));
    s.push_back(mk("t5_edge", 4'd0, 4'b0000, 3'd0, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b1000, 2'd0, 1'b1, 6'b110001)));
    s.push_back(mk("t5_take", 4'd0, 4'b0000, 3'd0, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd3, 4'b0000, 2'd1, 1'b1, 6'b110010)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    // Asynchronous reset between edges while waiting for the acknowledge
    reset = 1'b0;
    sb.push_back('{"t5_async_rst", 16'd0});
    #2;
    e = sb.pop_front();
    vectors++;
    if (obs() !== e.exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    sb_t e;
    do_reset(4'b0001);
    s.push_back(mk("t6_rstedge", 4'd7, 4'd0, 3'd0, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, ew(1'b0, 2'd0, 4'b0001, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t6_tk0",     4'd0, 4'd0, 3'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd0, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t6_ack0",    4'd7, 4'd0, 3'd0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd0, 4'b0000, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t6_e1",      4'd0, 4'd0, 3'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b0010, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t6_poponly", 4'd6, 4'd0, 3'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b0, 2'd0, 4'b0010, 2'd0, 1'b0, 6'b000001)));
    s.push_back(mk("t6_tk1",     4'd0, 4'd0, 3'd0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t6_ack1",    4'd0, 4'd0, 3'd0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t6_ie",      4'd7, 4'd0, 3'd0, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd1, 4'b0000, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t6_e2",      4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd1, 4'b0100, 2'd1, 1'b0, 6'b000011)));
    s.push_back(mk("t6_tk2_ic",  4'd8, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b1, 1'b0, ew(1'b1, 2'd2, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t6_ack2",    4'd0, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b1, ew(1'b0, 2'd2, 4'b0000, 2'd2, 1'b0, 6'b000010)));
    s.push_back(mk("t6_pop2",    4'd6, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd2, 4'b0000, 2'd1, 1'b0, 6'b000010)));
    s.push_back(mk("t6_pop1",    4'd6, 4'd0, 3'd0, 4'b0111, 1'b0, 4'b0000, 1'b0, 1'b0, ew(1'b0, 2'd2, 4'b0000, 2'd0, 1'b0, 6'b000001)));
    foreach (s[i]) begin
      drive(s[i]);
      sb.push_back('{s[i].name, s[i].exp});
      @(posedge clock);
      #1;
      e = sb.pop_front();
      vectors++;
      if (obs() !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    test_reset();
    test_basic_take();
    test_flags();
    test_priority_mask();
    test_stack_full();
    test_underflow_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_interrupt_controller.md
# status_interrupt_controller

Next-generation status register for the control unit: holds the NZCV flags and mode bit, and adds a global interrupt-enable bit plus an `IRQ_COUNT`-channel edge-triggered interrupt controller. Taking an interrupt pushes the full status word onto a nested stack of depth `STACK_DEPTH`, and a return pops it. The block sits beside the instruction decoder and branch-condition logic. It feeds flags to both, and raises a take/acknowledge handshake to the core sequencer at instruction boundaries.

## Interface
- `IRQ_COUNT`, 4: number of interrupt lines (≥1); `IDX_W = max(1, clog2(IRQ_COUNT))`.
- `STACK_DEPTH`, 4: saved-status entries (≥1); `DEPTH_W = clog2(STACK_DEPTH+1)`.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low.
- `update_mode` in 4: status command: 0 hold; 1 NZCV←ALU; 2 NZ←ALU; 3 NZC←BS; 4 mode←0; 5 mode←1; 6 return-from-interrupt; 7 I←1; 8 I←0; 9–15 hold.
- `alu_negative, alu_zero, alu_carry, alu_overflow` in 1 each: ALU flag sources.
- `bs_negative, bs_zero, bs_carry` in 1 each: barrel-shifter flag sources.
- `irq_lines` in IRQ_COUNT: raw interrupt requests, rising-edge sensitive.
- `irq_mask_write` in 1: load `irq_mask_data` into the mask register.
- `irq_mask_data` in IRQ_COUNT: bit i = 1 enables line i.
- `instruction_boundary` in 1: core is between instructions; interrupt may be taken.
- `irq_ack` in 1: core has redirected to the vector.
- `negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag, interrupt_enable_flag` out 1 each: registered status.
- `take_interrupt` out 1: registered; high from take until acknowledged.
- `irq_index` out IDX_W: channel being taken; valid while `take_interrupt`.
- `pending` out IRQ_COUNT: latched pending bits.
- `nest_depth` out DEPTH_W: occupied stack entries.
- `stack_underflow` out 1: sticky; return executed with empty stack.

## Operation
- Reset values (asynchronous, on `reset`=0): all flags 0, `mode_flag`=0, `interrupt_enable_flag`=0, mask 0, `pending` 0, edge-history register 0, `nest_depth` 0, `take_interrupt` 0, `irq_index` 0, `stack_underflow` 0, FSM=READY. Stack contents are don't-care.
- Edge detection: `prev` ← `irq_lines` every cycle. `pending` ← (`pending` & ~clear) | (`irq_lines` & ~`prev`). A new edge on a bit wins over a same-cycle clear. A line already high when reset is released counts as an edge.
- Mask gates eligibility only; masked edges still latch into `pending`.
- eligible = `pending` & mask. Winner = lowest set index (index 0 has highest priority).
- FSM READY: take condition = `interrupt_enable_flag` & `instruction_boundary` & (eligible≠0) & (`nest_depth` < `STACK_DEPTH`) & (`update_mode`≠6).
- On take, at the edge:
  - push {N,Z,C,V,mode,I}; the pushed value includes any flag update commanded in the same cycle;
  - `nest_depth`+1, `mode_flag`←1, `interrupt_enable_flag`←0;
  - clear `pending[winner]`, `irq_index`←winner, `take_interrupt`←1;
  - go to WAIT_ACK.
- FSM WAIT_ACK: `take_interrupt` held; no further takes. `irq_ack`=1 → `take_interrupt`←0, READY at that edge.
- Return (code 6) with `nest_depth`>0: pop all six bits, `nest_depth`−1. Return beats a same-cycle take; the take is re-evaluated next cycle.
- Return with `nest_depth`=0: status unchanged, `stack_underflow`←1 (held until reset).
- Stack full with eligible request: no take, no error; the request stays pending.
- Nesting: software re-enables I (code 7) inside the handler; a higher- or lower-priority pending line may then be taken.
- Flag commands 1–5, 7, 8 always apply in their cycle. The take's forced mode/I values override commands 5/7/8 in the same cycle.
- Reset mid-handshake or mid-nest: everything returns to reset values at once; stack is abandoned.

## Timing
- Every output is registered; none has a combinational path from inputs.
- Edge on `irq_lines` sampled at edge k → `pending` bit visible after edge k.
- Take condition true in cycle before edge m → `take_interrupt`, `irq_index`, mode=1, I=0 visible after edge m.
- Minimum latency from IRQ edge to `take_interrupt`: 2 edges.
- `irq_ack` sampled at edge n → `take_interrupt` low after n. Earliest next take is at edge n+1.
- Flag commands take effect at the next edge; pop restores at the next edge.

## Test plan
- Reset release, mask=4'b1111, I set via code 7, `irq_lines`=4'b0100 with boundary high → `take_interrupt`=1 two edges later, `irq_index`=2, mode=1, I=0, `nest_depth`=1, `pending`=0.
- Flags N=1,C=1 via code 1, take, then code 2 with ALU Z=1, then code 6 → N=1,Z=0,C=1,V=0, mode=0, I=1, depth 0.
- Lines 1 and 3 rise together, mask=4'b1000 → index 3 taken; bit 1 stays pending. Mask 4'b1111, re-enable I, ack → index 1 taken, depth 2.
- `STACK_DEPTH`=2: fill two levels, raise line 0 with I=1 → no take, `pending[0]`=1. After code 6 → taken next eligible boundary.
- Code 6 at depth 0 → `stack_underflow`=1, flags unchanged. Assert `reset`=0 mid-WAIT_ACK → all outputs at reset values immediately.
- Code 6 and take condition in the same cycle → pop only. Take occurs the following cycle if still eligible.
